seq_player: RTL and testbench
=============================

Name: seq_player

Overview:
- Playback sequencer for the Simon Says game: steps through a stored colour sequence and drives the four LEDs and the tone generator with millisecond-timed ON/GAP phases.
- Sits between the game FSM, which issues start/abort and owns the sequence memory, and the LED/sound outputs.
- Reads one sequence entry per step through a combinational read port and reports busy/done to the FSM.

Parameters:
- MAX_LEN, 32: maximum sequence length.
- ADDR_W, 5: sequence address width; must satisfy 2**ADDR_W >= MAX_LEN.
- ON_MS, 400: LED/tone on-time per step, in ms.
- GAP_MS, 200: dark gap after each step, in ms.
- TPM_W, 16: width of ticks_per_milli.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ticks_per_milli  input  TPM_W  clk cycles per millisecond.
- start  input  1  single-cycle request to begin playback.
- abort  input  1  stop playback immediately.
- length  input  ADDR_W+1  number of steps to play (0..2**ADDR_W).
- rd_addr  output  ADDR_W  sequence memory read address.
- rd_data  input  2  colour index at rd_addr; combinational, valid in the same cycle.
- led  output  4  one-hot LED drive.
- tone_en  output  1  tone generator enable.
- tone_sel  output  2  tone select (equals the colour index).
- busy  output  1  high whenever the block is not IDLE.
- done  output  1  one-cycle pulse when playback completes.

Behaviour:
- Reset (async, any state): state=IDLE; led=0, tone_en=0, tone_sel=0, rd_addr=0, busy=0, done=0; idx, ms and tick counters cleared.
- States: IDLE, FETCH, ON, GAP, DONE. All outputs are registered.
- IDLE, start=1:
  - Latch len_q = min(length, MAX_LEN) and tpm_q = max(ticks_per_milli, 1).
  - Set idx=0.
  - Next state is FETCH if len_q>0, otherwise DONE.
- start while not IDLE: ignored. length and ticks_per_milli changes after start have no effect.
- FETCH (1 cycle): rd_addr=idx; capture rd_data into colour register; next state ON.
- ON:
  - led=1<<colour, tone_en=1, tone_sel=colour.
  - Lasts exactly ON_MS*tpm_q cycles, then GAP.
- GAP:
  - led=0, tone_en=0.
  - Lasts exactly GAP_MS*tpm_q cycles.
  - Then DONE if idx==len_q-1; otherwise idx+1 and FETCH.
- DONE (1 cycle): done=1, led=0, tone_en=0; next state IDLE.
- busy=1 in FETCH, ON, GAP and DONE.
- Timing:
  - Prescaler counts 0..tpm_q-1 and pulses ms_tick on the terminal count.
  - The ms counter counts ms_ticks.
  - Both counters clear on every entry to ON or GAP, so each phase is exact with no carry-over.
- Cycle budget per step: 1 + (ON_MS+GAP_MS)*tpm_q. Total for N steps: N*(1+(ON_MS+GAP_MS)*tpm_q) + 1 (DONE), counted from the cycle after start is sampled.
- abort=1 in any non-IDLE state:
  - Next state IDLE; led=0, tone_en=0, busy=0.
  - No done pulse.
  - abort has priority over phase completion in the same cycle.
  - abort in IDLE is ignored.
- abort and start together in IDLE: start wins.
- Counter widths: ms counter is sized for max(ON_MS, GAP_MS); tick counter is TPM_W bits.

Test Plan (ON_MS=2, GAP_MS=1, tpm=3, so ON=6 cycles, GAP=3 cycles, 10 cycles per step; start sampled at edge 0):
- Sequence memory {2,0,3}, length=3:
  - Required: FETCH at cycle 1; led=0100, tone_sel=2 for cycles 2-7; led=0 for cycles 8-10.
  - Then led=0001 for cycles 12-17 and led=1000 for cycles 22-27.
  - done=1 only at cycle 31; busy falls at cycle 32.
- length=0 with start: done pulses at cycle 1; led and tone_en stay 0; busy=1 at cycle 1 only.
- Abort: length=3, abort asserted at cycle 13 (step 2 ON) -> led=0, tone_en=0, busy=0 from cycle 14; done never pulses.
- ticks_per_milli=0, length=1: ON lasts 2 cycles, GAP 1 cycle, done at cycle 5.
- Ignored start and length clamp:
  - A second start at cycle 5 with length=5 has no effect: playback of 3 steps is unchanged.
  - length=40 plays 32 steps, rd_addr 0..31 exactly once each.
- Async rst pulsed mid-ON: all outputs 0 immediately, without waiting for a clk edge; a fresh start afterwards replays from idx 0.

Source files
------------

// File: rtl/seq_player.sv
// seq_player: Simon Says playback sequencer. Walks the stored colour
// sequence, lighting one LED and enabling the tone for ON_MS, then a dark
// GAP_MS, per step. All outputs are registered from the next state.
module seq_player #(
   parameter int MAX_LEN = 32,
   parameter int ADDR_W  = 5,
   parameter int ON_MS   = 400,
   parameter int GAP_MS  = 200,
   parameter int TPM_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TPM_W-1:0]  ticks_per_milli,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [1:0]        rd_data,
   output logic [3:0]        led,
   output logic              tone_en,
   output logic [1:0]        tone_sel,
   output logic              busy,
   output logic              done
);

   localparam int MS_MAX = (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
   localparam int MSW    = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
   localparam logic [MSW-1:0]  ON_LAST   = MSW'(ON_MS - 1);
   localparam logic [MSW-1:0]  GAP_LAST  = MSW'(GAP_MS - 1);
   localparam logic [ADDR_W:0] MAX_LEN_V = (ADDR_W+1)'(MAX_LEN);

   typedef enum logic [2:0] {st_idle, st_fetch, st_on, st_gap, st_done} state_t;

   state_t            state, nstate;
   logic [ADDR_W:0]   len_q, len_in;
   logic [TPM_W-1:0]  tpm_q, tpm_in, tick_q;
   logic [MSW-1:0]    ms_q;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        colour, col_d;
   logic              ms_tick, phase_end, last_step;
   logic [3:0]        led_d;
   logic              tone_en_d, busy_d, done_d;
   logic [1:0]        tone_sel_d;

   // Clamp the requested length and keep the prescaler from dividing by zero.
   assign len_in    = (length > MAX_LEN_V) ? MAX_LEN_V : length;
   assign tpm_in    = (ticks_per_milli == '0) ? TPM_W'(1) : ticks_per_milli;
   assign ms_tick   = (tick_q == tpm_q - 1'b1);
   assign phase_end = ms_tick && (((state == st_on)  && (ms_q == ON_LAST)) ||
                                  ((state == st_gap) && (ms_q == GAP_LAST)));
   assign last_step = ({1'b0, idx} == len_q - 1'b1);
   assign rd_addr   = idx;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= st_idle;
      else     state <= nstate;
   end

   // Next-state logic; abort beats phase completion, start beats abort in idle.
   always_comb begin
      nstate = state;
      case (state)
         st_idle:  if (start) nstate = (len_in != '0) ? st_fetch : st_done;
         st_fetch: nstate = abort ? st_idle : st_on;
         st_on:    if (abort) nstate = st_idle;
                   else if (phase_end) nstate = st_gap;
         st_gap:   if (abort) nstate = st_idle;
                   else if (phase_end) nstate = last_step ? st_done : st_fetch;
         st_done:  nstate = st_idle;
         default:  nstate = st_idle;
      endcase
   end

   // Output decode from the next state so the registered outputs track state.
   always_comb begin
      col_d      = (state == st_fetch) ? rd_data : colour;
      led_d      = (nstate == st_on) ? (4'b0001 << col_d) : 4'b0000;
      tone_en_d  = (nstate == st_on);
      tone_sel_d = (nstate == st_on) ? col_d : tone_sel;
      busy_d     = (nstate != st_idle);
      done_d     = (nstate == st_done);
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led      <= '0;
         tone_en  <= 1'b0;
         tone_sel <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         led      <= led_d;
         tone_en  <= tone_en_d;
         tone_sel <= tone_sel_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   // Step bookkeeping: latch job parameters, colour capture, index advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q  <= '0;
         tpm_q  <= '0;
         idx    <= '0;
         colour <= '0;
      end else begin
         if (state == st_idle && start) begin
            len_q <= len_in;
            tpm_q <= tpm_in;
            idx   <= '0;
         end
         if (state == st_fetch) colour <= rd_data;
         if (state == st_gap && nstate == st_fetch) idx <= idx + 1'b1;
      end
   end

   // Millisecond timing; both counters restart on any state change so every
   // ON and GAP phase starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q <= '0;
         ms_q   <= '0;
      end else if (nstate != state || !(state == st_on || state == st_gap)) begin
         tick_q <= '0;
         ms_q   <= '0;
      end else if (ms_tick) begin
         tick_q <= '0;
         ms_q   <= ms_q + 1'b1;
      end else begin
         tick_q <= tick_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: a per-cycle expected-output scoreboard is filled when
// a playback is started and drained, one entry per clock, at the falling edge.
module tb_seq_player;
   localparam int ADDR_W = 5, MAX_LEN = 32, ON_MS = 2, GAP_MS = 1, TPM_W = 16;

   logic              clk = 1'b0, rst = 1'b1;
   logic [TPM_W-1:0]  ticks_per_milli = '0;
   logic              start = 1'b0, abort = 1'b0;
   logic [ADDR_W:0]   length = '0;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_data;
   logic [3:0]        led;
   logic              tone_en;
   logic [1:0]        tone_sel;
   logic              busy, done;
   logic [1:0]        mem [0:31];

   assign rd_data = mem[rd_addr];
   always #5 clk = ~clk;

   seq_player #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .ON_MS(ON_MS),
                .GAP_MS(GAP_MS), .TPM_W(TPM_W)) dut (
      .clk(clk), .rst(rst), .ticks_per_milli(ticks_per_milli), .start(start),
      .abort(abort), .length(length), .rd_addr(rd_addr), .rd_data(rd_data),
      .led(led), .tone_en(tone_en), .tone_sel(tone_sel), .busy(busy), .done(done));

   typedef struct packed {
      logic [3:0]        led;
      logic              te;
      logic [1:0]        sel;
      logic              busy;
      logic              done;
      logic [ADDR_W-1:0] rd;
      logic              chk;
   } exp_t;

   exp_t              sb[$];
   int                checks = 0, failures = 0;
   int                gen_c, gen_abort;
   logic [ADDR_W-1:0] gen_rd;

   task automatic chk(input string tag, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d got=%h exp=%h", tag, c, act, exp);
      end
   endtask

   // One expected cycle; cycles past the abort point are idle with rd_addr held.
   task automatic push(input logic [3:0] l, input logic te, input logic [1:0] s,
                       input logic b, input logic d, input logic [ADDR_W-1:0] r);
      exp_t e;
      gen_c++;
      if (gen_abort > 0 && gen_c > gen_abort)
         e = '{4'b0, 1'b0, 2'b0, 1'b0, 1'b0, gen_rd, 1'b0};
      else begin
         e = '{l, te, s, b, d, r, te};
         gen_rd = r;
      end
      sb.push_back(e);
   endtask

   // Reference playback: FETCH, ON_MS*tpm lit cycles, GAP_MS*tpm dark, then DONE.
   task automatic gen_play(input int n, input int tpm, input int abort_at);
      gen_c = 0;
      gen_abort = abort_at;
      gen_rd = '0;
      for (int i = 0; i < n; i++) begin
         push(4'b0, 1'b0, 2'b0, 1'b1, 1'b0, ADDR_W'(i));
         for (int k = 0; k < ON_MS * tpm; k++)
            push(4'b0001 << mem[i], 1'b1, mem[i], 1'b1, 1'b0, ADDR_W'(i));
         for (int k = 0; k < GAP_MS * tpm; k++)
            push(4'b0, 1'b0, 2'b0, 1'b1, 1'b0, ADDR_W'(i));
      end
      push(4'b0, 1'b0, 2'b0, 1'b1, 1'b1, (n > 0) ? ADDR_W'(n - 1) : '0);
      for (int k = 0; k < 2; k++) push(4'b0, 1'b0, 2'b0, 1'b0, 1'b0, gen_rd);
   endtask

   // Drive a start (optionally with abort) sampled at the next rising edge,
   // then scramble length/ticks to show they are not re-sampled.
   task automatic do_start(input int len, input int tpm, input logic ab);
      start = 1'b1;
      abort = ab;
      length = (ADDR_W+1)'(len);
      ticks_per_milli = TPM_W'(tpm);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      length = 6'd9;
      ticks_per_milli = 16'd7;
   endtask

   // Drain the scoreboard one cycle per falling edge, with optional injected
   // start/abort pulses after given cycles; maxc>0 stops early.
   task automatic run_sb(input string tag, input int start2_at, input int abort_at, input int maxc);
      int   c;
      exp_t e;
      c = 0;
      while (sb.size() > 0 && (maxc == 0 || c < maxc)) begin
         @(negedge clk);
         c++;
         e = sb.pop_front();
         chk(tag, c, {18'b0, led, tone_en, (e.chk ? tone_sel : 2'b0), busy, done, rd_addr},
                     {18'b0, e.led, e.te, (e.chk ? e.sel : 2'b0), e.busy, e.done, e.rd});
         start = (c == start2_at);
         if (c == start2_at) length = 6'd5;
         abort = (c == abort_at);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));
      #1;
      chk("rst_led", 0, 32'(led), 32'h0);
      chk("rst_tone_en", 0, 32'(tone_en), 32'h0);
      chk("rst_tone_sel", 0, 32'(tone_sel), 32'h0);
      chk("rst_rd_addr", 0, 32'(rd_addr), 32'h0);
      chk("rst_busy", 0, 32'(busy), 32'h0);
      chk("rst_done", 0, 32'(done), 32'h0);
      #12 rst = 1'b0;
      @(negedge clk);

      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
      gen_play(3, 3, 0);   do_start(3, 3, 1'b0);  run_sb("play3", 0, 0, 0);
      gen_play(3, 3, 0);   do_start(3, 3, 1'b0);  run_sb("start2", 5, 0, 0);
      gen_play(0, 3, 0);   do_start(0, 3, 1'b0);  run_sb("len0", 0, 0, 0);
      gen_play(3, 3, 13);  do_start(3, 3, 1'b0);  run_sb("abort", 0, 13, 0);
      gen_play(1, 1, 0);   do_start(1, 0, 1'b1);  run_sb("tpm0", 0, 0, 0);
      gen_play(32, 1, 0);  do_start(40, 1, 1'b0); run_sb("clamp", 0, 0, 0);

      // Asynchronous reset in the middle of the first ON phase.
      gen_play(3, 3, 0);   do_start(3, 3, 1'b0);  run_sb("pre_rst", 0, 0, 3);
      sb.delete();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_led", 4, 32'(led), 32'h0);
      chk("arst_tone_en", 4, 32'(tone_en), 32'h0);
      chk("arst_tone_sel", 4, 32'(tone_sel), 32'h0);
      chk("arst_busy", 4, 32'(busy), 32'h0);
      chk("arst_done", 4, 32'(done), 32'h0);
      #1 rst = 1'b0;
      @(negedge clk);
      gen_play(3, 3, 0);   do_start(3, 3, 1'b0);  run_sb("replay", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
